// File: rtl/io_terminal_uart_if.sv
// CPU-facing register/flag bundle of the serial terminal: INPR/FGI input side, OUTR/FGO output side.
// master = CPU (drives OUTR/out_load/inp_ack), slave = terminal (drives data and flags).
interface io_terminal_uart_if;
    logic [7:0] INPR;
    logic       FGI;
    logic       inp_ack;
    logic [7:0] OUTR;
    logic       out_load;
    logic       FGO;
    logic       rx_overrun;
    logic       rx_frame_err;

    modport master (
        output OUTR,
        output out_load,
        output inp_ack,
        input  INPR,
        input  FGI,
        input  FGO,
        input  rx_overrun,
        input  rx_frame_err
    );

    modport slave (
        input  OUTR,
        input  out_load,
        input  inp_ack,
        output INPR,
        output FGI,
        output FGO,
        output rx_overrun,
        output rx_frame_err
    );
endinterface

// File: rtl/io_terminal_uart.sv
// 8N1 terminal UART: RX sets FGI 2 + 9.5 bits + 1 cycles after the start edge; TX frame is 10 bits load-to-FGO.
// No backpressure: a byte arriving with FGI=1 is dropped (overrun), out_load with FGO=0 is ignored.
module io_terminal_uart #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              tx,
    io_terminal_uart_if.slave bus
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    // ------------------------------------------------------------------
    // RX synchroniser; rx_prev_q gives the previous synchronised sample
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    state_e      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q,   rx_cnt_d;
    logic [2:0]  rx_bit_q,   rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  inpr_q,     inpr_d;
    logic        fgi_q,      fgi_d;
    logic        ovr_q,      ovr_d;
    logic        ferr_q,     ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            inpr_q     <= 8'd0;
            fgi_q      <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            inpr_q     <= inpr_d;
            fgi_q      <= fgi_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        inpr_d     = inpr_q;
        fgi_d      = bus.inp_ack ? 1'b0 : fgi_q;
        ovr_d      = bus.inp_ack ? 1'b0 : ovr_q;
        ferr_d     = ferr_q;

        unique case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = 16'd0;
                rx_bit_d = 3'd0;
                if (rx_prev_q && !rx_s_q) begin
                    rx_state_d = ST_START;
                end
            end

            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = 16'd0;
                    rx_state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end

            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end

            ST_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = 16'd0;
                    rx_state_d = ST_IDLE;
                    // An ack on the stop-sample cycle frees INPR in time for the new byte.
                    if (rx_s_q) begin
                        if (!fgi_q || bus.inp_ack) begin
                            inpr_d = rx_shift_q;
                            fgi_d  = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end

            default: rx_state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transmitter; tx is registered so it leaves the load edge low
    // ------------------------------------------------------------------
    state_e      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q,   tx_cnt_d;
    logic [2:0]  tx_bit_q,   tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q,       tx_d;
    logic        fgo_q,      fgo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            tx_q       <= 1'b1;
            fgo_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            fgo_q      <= fgo_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        fgo_d      = fgo_q;

        unique case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = 16'd0;
                tx_bit_d = 3'd0;
                tx_d     = 1'b1;
                if (bus.out_load && fgo_q) begin
                    tx_shift_d = bus.OUTR;
                    fgo_d      = 1'b0;
                    tx_d       = 1'b0;
                    tx_state_d = ST_START;
                end
            end

            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = 16'd0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end

            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = 16'd0;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end

            ST_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = 16'd0;
                    fgo_d      = 1'b1;
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end

            default: tx_state_d = ST_IDLE;
        endcase
    end

    assign tx               = tx_q;
    assign bus.INPR         = inpr_q;
    assign bus.FGI          = fgi_q;
    assign bus.FGO          = fgo_q;
    assign bus.rx_overrun   = ovr_q;
    assign bus.rx_frame_err = ferr_q;

endmodule

// File: tb/tb_io_terminal_uart.sv
// Randomised bench for io_terminal_uart against a frame-level model of INPR/FGI/overrun/frame-error
// and a bit-level expectation of the transmitted waveform and FGO timing.
module tb_io_terminal_uart;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rx_drv;
    logic loop_en;
    wire  tx;
    wire  rx_w = loop_en ? tx : rx_drv;

    io_terminal_uart_if bus();

    io_terminal_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx_w),
        .tx   (tx),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_inpr;
    bit         m_fgi;
    bit         m_ovr;
    bit         m_ferr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_inpr = 8'h00;
        m_fgi  = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_inpr"}, 32'(bus.INPR), 32'(m_inpr));
        chk({tag, "_fgi"},  32'(bus.FGI), 32'(m_fgi));
        chk({tag, "_ovr"},  32'(bus.rx_overrun), 32'(m_ovr));
        chk({tag, "_ferr"}, 32'(bus.rx_frame_err), 32'(m_ferr));
    endtask

    // Frame-level effect of one received byte on the CPU-visible input state.
    task automatic model_rx(input logic [7:0] b, input bit stop_ok, input bit ack);
        if (stop_ok) begin
            if (!m_fgi || ack) begin
                m_inpr = b;
                m_fgi  = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
            if (ack) m_ovr = 1'b0;
        end else begin
            m_ferr = 1'b1;
            if (ack) begin
                m_fgi = 1'b0;
                m_ovr = 1'b0;
            end
        end
    endtask

    // Drives one 8N1 frame on rx; optional inp_ack lands on the stop-sample edge (155 cycles in).
    task automatic rx_frame(input logic [7:0] b, input bit stop_ok, input bit ack_at_stop);
        logic [9:0] fr;
        bit         fgi0;
        fr   = {stop_ok, b, 1'b0};
        fgi0 = m_fgi;
        for (int i = 0; i < 10 * CPB; i++) begin
            rx_drv      = fr[4'(i / CPB)];
            bus.inp_ack = ack_at_stop && (i == 154);
            if (i == 154 && !fgi0) chk("rx_fgi_early", 32'(bus.FGI), 32'd0);
            if (i == 155 && !fgi0 && stop_ok) chk("rx_fgi_latency", 32'(bus.FGI), 32'd1);
            @(posedge clk);
            #1;
        end
        bus.inp_ack = 1'b0;
        rx_drv      = 1'b1;
        model_rx(b, stop_ok, ack_at_stop);
        cyc(4);
    endtask

    task automatic ack_pulse();
        bus.inp_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.inp_ack = 1'b0;
        m_fgi = 1'b0;
        m_ovr = 1'b0;
        chk("ack_fgi_clr", 32'(bus.FGI), 32'd0);
        chk("ack_ovr_clr", 32'(bus.rx_overrun), 32'd0);
    endtask

    // Loads b and checks every cycle of the expected waveform and FGO until FGO returns.
    task automatic tx_frame(input logic [7:0] b, input bit load_at_50, input bit load_at_rise);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        chk("tx_fgo_ready", 32'(bus.FGO), 32'd1);
        bus.OUTR     = b;
        bus.out_load = 1'b1;
        @(posedge clk);
        #1;
        bus.out_load = 1'b0;
        for (int j = 0; j < 10 * CPB; j++) begin
            chk("tx_bit", 32'(tx), 32'(fr[4'(j / CPB)]));
            chk("tx_fgo_busy", 32'(bus.FGO), 32'd0);
            bus.out_load = (load_at_50 && j == 50) || (load_at_rise && j == 159);
            if (load_at_50 && j == 50) bus.OUTR = 8'h99;
            @(posedge clk);
            #1;
        end
        bus.out_load = 1'b0;
        chk("tx_fgo_done", 32'(bus.FGO), 32'd1);
        chk("tx_idle", 32'(tx), 32'd1);
        if (load_at_rise) begin
            cyc(3);
            chk("tx_rise_load_fgo", 32'(bus.FGO), 32'd1);
            chk("tx_rise_load_tx", 32'(tx), 32'd1);
        end
    endtask

    initial begin
        logic [7:0] b;
        bit         sok;
        bit         ak;

        rst_n        = 1'b1;
        rx_drv       = 1'b1;
        loop_en      = 1'b0;
        bus.inp_ack  = 1'b0;
        bus.out_load = 1'b0;
        bus.OUTR     = 8'h00;
        model_reset();

        #2 rst_n = 1'b0;
        #1;
        check_rx("reset");
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_fgo", 32'(bus.FGO), 32'd1);
        cyc(3);
        rst_n = 1'b1;
        cyc(4);
        chk("idle_tx", 32'(tx), 32'd1);

        rx_frame(8'h4B, 1'b1, 1'b0);
        check_rx("rx_4b");
        ack_pulse();
        check_rx("rx_4b_ack");

        rx_frame(8'h31, 1'b1, 1'b0);
        rx_frame(8'h32, 1'b1, 1'b0);
        check_rx("overrun");
        ack_pulse();
        check_rx("overrun_ack");

        rx_drv = 1'b0;
        cyc(4);
        rx_drv = 1'b1;
        cyc(30);
        check_rx("glitch");

        rx_frame(8'h55, 1'b0, 1'b0);
        check_rx("frame_err");

        tx_frame(8'hC3, 1'b1, 1'b0);
        tx_frame(8'h5A, 1'b0, 1'b1);

        loop_en = 1'b1;
        cyc(4);
        tx_frame(8'h7E, 1'b0, 1'b0);
        model_rx(8'h7E, 1'b1, 1'b0);
        cyc(4);
        check_rx("loopback");
        loop_en = 1'b0;
        cyc(4);

        rx_frame(8'hE7, 1'b1, 1'b1);
        check_rx("ack_at_stop");

        for (int k = 0; k < 8; k++) begin
            b   = 8'($urandom);
            sok = ($urandom_range(0, 5) != 0);
            ak  = ($urandom_range(0, 3) == 0);
            rx_frame(b, sok, ak);
            check_rx("rand_rx");
            if ($urandom_range(0, 1) == 1) ack_pulse();
        end

        if (m_fgi) ack_pulse();
        b = 8'($urandom);
        fork
            rx_frame(8'hA6, 1'b1, 1'b0);
            tx_frame(b, 1'b0, 1'b0);
        join
        check_rx("simul");

        bus.OUTR     = 8'hA5;
        bus.out_load = 1'b1;
        @(posedge clk);
        #1;
        bus.out_load = 1'b0;
        cyc(4);
        chk("pre_reset_tx", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_rx("mid_reset");
        chk("mid_reset_tx", 32'(tx), 32'd1);
        chk("mid_reset_fgo", 32'(bus.FGO), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(20);
        chk("post_reset_tx", 32'(tx), 32'd1);
        chk("post_reset_fgo", 32'(bus.FGO), 32'd1);
        check_rx("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/io_terminal_uart.md
Name: io_terminal_uart

Overview:
- Serial terminal interface feeding the basic computer's input side and consuming its output side.
- Receiver assembles 8N1 serial bytes into INPR and raises FGI. The CPU reads INPR on INP and acknowledges.
- Transmitter captures OUTR on OUT, clears FGO, serialises the byte, then re-raises FGO. This gives the CPU its ready/skip flags (SKI/SKO) and interrupt sources.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..65535; half-bit point = floor(CLKS_PER_BIT/2).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rx  in  1  serial input, idle high, asynchronous to clk.
- tx  out  1  serial output, idle high.
- INPR  out  8  received byte presented to CPU.
- FGI  out  1  input flag; 1 = INPR holds an unread byte.
- inp_ack  in  1  one-cycle pulse when CPU executes INP; clears FGI and rx_overrun.
- OUTR  in  8  CPU output register.
- out_load  in  1  one-cycle pulse when CPU executes OUT; captures OUTR.
- FGO  out  1  output flag; 1 = transmitter ready for a byte.
- rx_overrun  out  1  sticky: a byte arrived while FGI=1 and was dropped.
- rx_frame_err  out  1  sticky: stop bit sampled low; cleared only by reset.

Behaviour:
- Reset (rst_n=0, async): tx=1, INPR=0, FGI=0, FGO=1, rx_overrun=0, rx_frame_err=0, both FSMs IDLE, counters 0. Any partial frame is discarded. tx goes high immediately, including when reset arrives mid-frame.
- rx passes through a 2-flop synchroniser; all RX decisions use the synchronised value (rx_s).

RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: falling edge of rx_s (previous 1, current 0) -> START, bit counter cleared.
- START: at half-bit count, sample rx_s.
  - 0 -> DATA, counter cleared.
  - 1 -> IDLE (glitch rejected, nothing recorded).
- DATA: sample at every CLKS_PER_BIT count, LSB first, 8 samples -> STOP.
- STOP: sample after CLKS_PER_BIT count.
  - 1 and FGI=0: INPR<=byte, FGI<=1.
  - 1 and FGI=1: byte dropped, INPR unchanged, rx_overrun<=1.
  - 0: byte dropped, rx_frame_err<=1; return to IDLE. A new start needs rx_s high first.
- FGI rises on the clk edge after the stop-bit sample. End-to-end latency from the rx start edge to FGI=1 is 2 synchroniser cycles + 9.5 bit times + 1.
- inp_ack clears FGI and rx_overrun on the next edge.
- inp_ack in the same cycle as a good stop sample: store proceeds (INPR=new byte), FGI stays 1, no overrun.
- inp_ack while FGI=0 is a no-op.

TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- out_load with FGO=1: shift register<=OUTR, FGO<=0, go to START. tx goes low on the same edge.
- out_load with FGO=0 is ignored; the byte is lost and the transmitter state is unchanged.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
- STOP: tx=1 for CLKS_PER_BIT cycles; then FGO<=1 and go to IDLE.
- Frame = 10*CLKS_PER_BIT cycles from the load edge to the FGO rise.
- out_load on the same edge FGO rises is ignored, because FGO=1 is first seen the following cycle.

General rules:
- RX and TX are fully independent and may run simultaneously; loopback (tx tied to rx) must work.
- Bit-timing counters wrap to 0 at CLKS_PER_BIT-1; no drift across a frame.

Test Plan (CLKS_PER_BIT=16):
- Reset values: assert rst_n=0 mid-TX-frame of 0xA5 -> tx=1, FGO=1, FGI=0 and INPR=0x00 within the same cycle, with no clk edge needed. After release, idle with tx=1.
- RX byte 0x4B (8N1, 16 clk/bit): FGI=1 and INPR=0x4B after the stop sample. inp_ack pulse -> FGI=0 next edge, INPR still 0x4B.
- Overrun and glitch:
  - Send 0x31, no ack, then 0x32 -> INPR=0x31, rx_overrun=1; inp_ack clears both flags.
  - rx low for 4 cycles only -> no state change.
- Frame error: send 0x55 with the stop bit held low -> rx_frame_err=1, FGI=0, INPR unchanged.
- TX 0xC3 via out_load, checking the waveform and FGO:
  - tx low for 16 cycles, then bits 1,1,0,0,0,0,1,1 at 16 cycles each, then high for 16.
  - FGO=0 for 160 cycles, then FGO=1.
  - A second out_load at cycle 50 (0x99) is ignored and 0xC3 is unaffected.
- Loopback and simultaneity: tx->rx, OUT 0x7E -> FGI=1 with INPR=0x7E. A new byte completing on the inp_ack cycle -> FGI stays 1 with no overrun.
